// File: rtl/sprite_pkg.sv
// Shared geometry defaults and flat-index helpers for the sprite address pipeline.
// Object vectors are packed lane-major, so every consumer must agree on these helpers.
package sprite_pkg;

    localparam int DEF_CELL         = 120;
    localparam int DEF_BULLET       = 20;
    localparam int DEF_BULLET_Y_OFF = 10;
    localparam int DEF_H_ACTIVE     = 640;
    localparam int DEF_V_ACTIVE     = 480;

    function automatic int plant_idx(input int lane, input int col, input int cols);
        return lane * cols + col;
    endfunction

    function automatic int zombie_idx(input int lane, input int slot, input int slots);
        return lane * slots + slot;
    endfunction

endpackage

// File: rtl/sprite_rect_hit.sv
// Combinational rectangle test: reports whether the pixel lies inside a W x H box
// anchored at a signed origin, and the pixel's offset within that box.
module sprite_rect_hit #(
    parameter int CW    = 13,
    parameter int W     = 20,
    parameter int H     = 20,
    parameter int OFF_W = 5
) (
    input  logic signed [CW-1:0] x0,
    input  logic signed [CW-1:0] y0,
    input  logic        [9:0]    h_cnt,
    input  logic        [9:0]    v_cnt,
    input  logic                 en,
    output logic                 hit,
    output logic        [OFF_W-1:0] dx,
    output logic        [OFF_W-1:0] dy
);

    localparam logic signed [CW-1:0] W_S = CW'(W);
    localparam logic signed [CW-1:0] H_S = CW'(H);

    logic signed [CW-1:0] hs;
    logic signed [CW-1:0] vs;
    logic signed [CW-1:0] rx;
    logic signed [CW-1:0] ry;

    assign hs = $signed(CW'(h_cnt));
    assign vs = $signed(CW'(v_cnt));
    assign rx = hs - x0;
    assign ry = vs - y0;

    // A negative origin lets a sprite slide partly off the left edge; the sign bit
    // of the relative offset rejects pixels left of / above the box.
    assign hit = en && !rx[CW-1] && (rx < W_S) && !ry[CW-1] && (ry < H_S);
    assign dx  = rx[OFF_W-1:0];
    assign dy  = ry[OFF_W-1:0];

endmodule

// File: rtl/sprite_addr_pipe.sv
// Two-stage sprite address generator: per-pixel plant, bullet and zombie ROM
// addresses and hit flags, with object state held in frame-latched shadows.
module sprite_addr_pipe
    import sprite_pkg::*;
#(
    parameter int LANES        = 4,
    parameter int PLANT_COLS   = 2,
    parameter int ZSLOTS       = 2,
    parameter int CELL         = DEF_CELL,
    parameter int BULLET       = DEF_BULLET,
    parameter int BULLET_Y_OFF = DEF_BULLET_Y_OFF,
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int POS_W        = 11,
    parameter int ADDR_W       = 17
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [9:0]                      h_cnt,
    input  logic [9:0]                      v_cnt,
    input  logic                            pix_valid,
    input  logic                            frame_start,
    input  logic [LANES*PLANT_COLS-1:0]       plant_en,
    input  logic [LANES*PLANT_COLS*POS_W-1:0] bullet_pos,
    input  logic [LANES*PLANT_COLS-1:0]       bullet_en,
    input  logic [LANES*ZSLOTS*POS_W-1:0]     zombie_pos,
    input  logic [LANES*ZSLOTS-1:0]           zombie_en,
    output logic [ADDR_W-1:0]               plant_addr,
    output logic                            plant_hit,
    output logic [ADDR_W-1:0]               bullet_addr,
    output logic                            bullet_hit,
    output logic [ZSLOTS*ADDR_W-1:0]        zombie_addr,
    output logic [ZSLOTS-1:0]               zombie_hit,
    output logic                            pix_valid_out
);

    localparam int CW  = POS_W + 2;
    localparam int NB  = LANES * PLANT_COLS;
    localparam int NZ  = LANES * ZSLOTS;
    localparam int BOW = $clog2(BULLET);
    localparam int ZOW = $clog2(CELL);

    logic [NB-1:0]       sh_plant_en;
    logic [NB*POS_W-1:0] sh_bullet_pos;
    logic [NB-1:0]       sh_bullet_en;
    logic [NZ*POS_W-1:0] sh_zombie_pos;
    logic [NZ-1:0]       sh_zombie_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_plant_en   <= '0;
            sh_bullet_pos <= '0;
            sh_bullet_en  <= '0;
            sh_zombie_pos <= '0;
            sh_zombie_en  <= '0;
        end else if (frame_start) begin
            sh_plant_en   <= plant_en;
            sh_bullet_pos <= bullet_pos;
            sh_bullet_en  <= bullet_en;
            sh_zombie_pos <= zombie_pos;
            sh_zombie_en  <= zombie_en;
        end
    end

    logic [9:0] lane;
    logic [9:0] ly;
    logic [9:0] col;
    logic [9:0] pdx;

    assign lane = v_cnt / 10'(CELL);
    assign ly   = v_cnt % 10'(CELL);
    assign col  = h_cnt / 10'(CELL);
    assign pdx  = h_cnt % 10'(CELL);

    logic [NB-1:0]  plant_sel;
    logic [NB-1:0]  b_hit_c;
    logic [BOW-1:0] b_dx_c [NB];
    logic [BOW-1:0] b_dy_c [NB];
    logic [NZ-1:0]  z_hit_c;
    logic [ZOW-1:0] z_dx_c [NZ];
    logic [ZOW-1:0] z_dy_c [NZ];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar c = 0; c < PLANT_COLS; c++) begin : g_col
            localparam int IDX = plant_idx(l, c, PLANT_COLS);
            localparam logic signed [CW-1:0] X_BASE = CW'(CELL * (c + 1));
            localparam logic signed [CW-1:0] Y_BASE = CW'(l * CELL + BULLET_Y_OFF);

            logic signed [CW-1:0] bx0;

            // Lanes beyond LANES have no select line, so v_cnt past the grid never hits.
            assign plant_sel[IDX] = (lane == 10'(l)) && (col == 10'(c));
            assign bx0 = X_BASE + $signed({2'b00, sh_bullet_pos[IDX*POS_W +: POS_W]});

            sprite_rect_hit #(
                .CW    (CW),
                .W     (BULLET),
                .H     (BULLET),
                .OFF_W (BOW)
            ) u_bullet (
                .x0    (bx0),
                .y0    (Y_BASE),
                .h_cnt (h_cnt),
                .v_cnt (v_cnt),
                .en    (sh_bullet_en[IDX]),
                .hit   (b_hit_c[IDX]),
                .dx    (b_dx_c[IDX]),
                .dy    (b_dy_c[IDX])
            );
        end

        for (genvar s = 0; s < ZSLOTS; s++) begin : g_slot
            localparam int IDX = zombie_idx(l, s, ZSLOTS);
            localparam logic signed [CW-1:0] X_SPAWN = CW'(H_ACTIVE - CELL);
            localparam logic signed [CW-1:0] Y_BASE  = CW'(l * CELL);

            logic signed [CW-1:0] zx0;

            assign zx0 = X_SPAWN - $signed({2'b00, sh_zombie_pos[IDX*POS_W +: POS_W]});

            sprite_rect_hit #(
                .CW    (CW),
                .W     (CELL),
                .H     (CELL),
                .OFF_W (ZOW)
            ) u_zombie (
                .x0    (zx0),
                .y0    (Y_BASE),
                .h_cnt (h_cnt),
                .v_cnt (v_cnt),
                .en    (sh_zombie_en[IDX]),
                .hit   (z_hit_c[IDX]),
                .dx    (z_dx_c[IDX]),
                .dy    (z_dy_c[IDX])
            );
        end
    end

    logic           v1;
    logic           p_hit1;
    logic [9:0]     p_dx1;
    logic [9:0]     ly1;
    logic [NB-1:0]  b_hit1;
    logic [BOW-1:0] b_dx1 [NB];
    logic [BOW-1:0] b_dy1 [NB];
    logic [NZ-1:0]  z_hit1;
    logic [ZOW-1:0] z_dx1 [NZ];
    logic [ZOW-1:0] z_dy1 [NZ];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1     <= 1'b0;
            p_hit1 <= 1'b0;
            p_dx1  <= '0;
            ly1    <= '0;
            b_hit1 <= '0;
            z_hit1 <= '0;
            for (int i = 0; i < NB; i++) begin
                b_dx1[i] <= '0;
                b_dy1[i] <= '0;
            end
            for (int i = 0; i < NZ; i++) begin
                z_dx1[i] <= '0;
                z_dy1[i] <= '0;
            end
        end else begin
            v1     <= pix_valid;
            p_hit1 <= pix_valid && |(plant_sel & sh_plant_en);
            p_dx1  <= pdx;
            ly1    <= ly;
            b_hit1 <= pix_valid ? b_hit_c : '0;
            z_hit1 <= pix_valid ? z_hit_c : '0;
            for (int i = 0; i < NB; i++) begin
                b_dx1[i] <= b_dx_c[i];
                b_dy1[i] <= b_dy_c[i];
            end
            for (int i = 0; i < NZ; i++) begin
                z_dx1[i] <= z_dx_c[i];
                z_dy1[i] <= z_dy_c[i];
            end
        end
    end

    logic              b_sel_hit;
    logic [ADDR_W-1:0] b_sel_addr;
    logic [ZSLOTS-1:0] z_sel_hit;
    logic [ADDR_W-1:0] z_sel_addr [ZSLOTS];
    logic [ADDR_W-1:0] p_addr;

    // Later iterations overwrite earlier ones, so the highest bullet index wins.
    always_comb begin
        b_sel_hit  = 1'b0;
        b_sel_addr = '0;
        for (int i = 0; i < NB; i++) begin
            if (b_hit1[i]) begin
                b_sel_hit  = 1'b1;
                b_sel_addr = ADDR_W'(32'(b_dx1[i]) + 32'(BULLET) * 32'(b_dy1[i]));
            end
        end
    end

    always_comb begin
        z_sel_hit = '0;
        for (int s = 0; s < ZSLOTS; s++) begin
            z_sel_addr[s] = '0;
            for (int l = 0; l < LANES; l++) begin
                if (z_hit1[zombie_idx(l, s, ZSLOTS)]) begin
                    z_sel_hit[s]  = 1'b1;
                    z_sel_addr[s] = ADDR_W'(32'(z_dx1[zombie_idx(l, s, ZSLOTS)])
                                  + 32'(CELL) * 32'(z_dy1[zombie_idx(l, s, ZSLOTS)]));
                end
            end
        end
    end

    assign p_addr = p_hit1 ? ADDR_W'(32'(p_dx1) + 32'(CELL) * 32'(ly1)) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_valid_out <= 1'b0;
            plant_hit     <= 1'b0;
            plant_addr    <= '0;
            bullet_hit    <= 1'b0;
            bullet_addr   <= '0;
            zombie_hit    <= '0;
            zombie_addr   <= '0;
        end else begin
            pix_valid_out <= v1;
            plant_hit     <= p_hit1;
            plant_addr    <= p_addr;
            bullet_hit    <= b_sel_hit;
            bullet_addr   <= b_sel_addr;
            zombie_hit    <= z_sel_hit;
            for (int s = 0; s < ZSLOTS; s++) begin
                zombie_addr[s*ADDR_W +: ADDR_W] <= z_sel_addr[s];
            end
        end
    end

endmodule
